// File: rtl/udp_rx_buf_ctrl_pkg.sv
// Shared types and constants for the UDP receive-buffer controller.
// Writer-state encoding, header size and drop-counter saturation helper.
package udp_rx_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_FILL = 2'd1,
    W_DROP = 2'd2
  } wr_state_e;

  localparam logic [15:0] UDP_HDR_BYTES = 16'd8;
  localparam logic [15:0] DROP_CNT_MAX  = 16'hFFFF;

  // Add a small increment to the drop counter, clamping at its maximum.
  function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, cnt} + {15'd0, inc};
    if (sum > {1'b0, DROP_CNT_MAX}) begin
      return DROP_CNT_MAX;
    end else begin
      return sum[15:0];
    end
  endfunction

endpackage

// File: rtl/udp_rx_buf_ctrl_if.sv
// Bus bundle between the UDP receiver, the bank RAM and the frame consumer.
// master = buffer controller side, slave = environment side.
interface udp_rx_buf_ctrl_if #(parameter int ADDR_W = 9);

  logic          rx_start;
  logic [15:0]   rx_len;
  logic [15:0]   rx_dst_port;
  logic [31:0]   rx_word;
  logic          rx_word_valid;
  logic          rx_end;
  logic          ram_we;
  logic [ADDR_W:0] ram_waddr;
  logic [31:0]   ram_wdata;
  logic          frm_ready;
  logic          frm_bank;
  logic [15:0]   frm_len;
  logic          frm_ack;
  logic [15:0]   drop_cnt;

  modport master (
    input  rx_start, rx_len, rx_dst_port, rx_word, rx_word_valid, rx_end, frm_ack,
    output ram_we, ram_waddr, ram_wdata, frm_ready, frm_bank, frm_len, drop_cnt
  );

  modport slave (
    output rx_start, rx_len, rx_dst_port, rx_word, rx_word_valid, rx_end, frm_ack,
    input  ram_we, ram_waddr, ram_wdata, frm_ready, frm_bank, frm_len, drop_cnt
  );

endinterface

// File: rtl/udp_rx_desc_q.sv
// Two-entry descriptor queue: bank pointers, occupancy and per-bank payload length.
// Push and pop may occur in the same cycle; presented-frame outputs are registered.
module udp_rx_desc_q (
  input  logic        clk,
  input  logic        clr,
  input  logic        push,
  input  logic [15:0] push_len,
  input  logic        pop_req,
  output logic        wr_bank,
  output logic        full,
  output logic        frm_ready,
  output logic        frm_bank,
  output logic [15:0] frm_len
);

  logic [1:0]  count_r;
  logic        wr_bank_r;
  logic        rd_bank_r;
  logic [15:0] len_r [2];
  logic        frm_ready_r;
  logic        frm_bank_r;
  logic [15:0] frm_len_r;

  logic        pop_s;
  logic        push_s;
  logic [1:0]  count_nxt_s;
  logic        wr_nxt_s;
  logic        rd_nxt_s;
  logic [15:0] len_nxt_s [2];

  // Next-state for occupancy, pointers and stored lengths.
  always_comb begin
    pop_s  = pop_req && (count_r != 2'd0);
    push_s = push && ((count_r != 2'd2) || pop_s);
    if (push_s && !pop_s) begin
      count_nxt_s = count_r + 2'd1;
    end else if (pop_s && !push_s) begin
      count_nxt_s = count_r - 2'd1;
    end else begin
      count_nxt_s = count_r;
    end
    wr_nxt_s     = wr_bank_r ^ push_s;
    rd_nxt_s     = rd_bank_r ^ pop_s;
    len_nxt_s[0] = len_r[0];
    len_nxt_s[1] = len_r[1];
    if (push_s) begin
      len_nxt_s[wr_bank_r] = push_len;
    end else begin
      len_nxt_s[wr_bank_r] = len_r[wr_bank_r];
    end
  end

  // Queue state plus registered view of the head descriptor.
  always_ff @(posedge clk) begin
    if (!clr) begin
      count_r     <= 2'd0;
      wr_bank_r   <= 1'b0;
      rd_bank_r   <= 1'b0;
      len_r[0]    <= 16'd0;
      len_r[1]    <= 16'd0;
      frm_ready_r <= 1'b0;
      frm_bank_r  <= 1'b0;
      frm_len_r   <= 16'd0;
    end else begin
      count_r     <= count_nxt_s;
      wr_bank_r   <= wr_nxt_s;
      rd_bank_r   <= rd_nxt_s;
      len_r[0]    <= len_nxt_s[0];
      len_r[1]    <= len_nxt_s[1];
      frm_ready_r <= (count_nxt_s != 2'd0);
      frm_bank_r  <= rd_nxt_s;
      frm_len_r   <= len_nxt_s[rd_nxt_s];
    end
  end

  assign wr_bank   = wr_bank_r;
  assign full      = (count_r == 2'd2);
  assign frm_ready = frm_ready_r;
  assign frm_bank  = frm_bank_r;
  assign frm_len   = frm_len_r;

endmodule

// File: rtl/udp_rx_buf_ctrl.sv
// Ping-pong receive-buffer controller: writes UDP payload words into two RAM banks,
// validates word count against UDP length and queues frames. Option: UDP_RX_PORT_FILTER_EN.
module udp_rx_buf_ctrl
  import udp_rx_pkg::*;
#(
  parameter int          ADDR_W  = 9,
  parameter logic [15:0] RX_PORT = 16'h1F90
) (
  input logic clk,
  input logic clr,
  udp_rx_buf_ctrl_if.master bus
);

  localparam logic [15:0] BANK_WORDS = 16'(1 << ADDR_W);

  wr_state_e       state_r;
  logic [15:0]     wcnt_r;
  logic [15:0]     exp_words_r;
  logic [15:0]     len_r;
  logic [15:0]     drop_cnt_r;
  logic            ram_we_r;
  logic [ADDR_W:0] ram_waddr_r;
  logic [31:0]     ram_wdata_r;

  logic            port_ok_s;
  logic            len_ok_s;
  logic            hdr_ok_s;
  logic            full_s;
  logic            overflow_s;
  logic            commit_s;
  logic            wr_bank_s;
  logic [15:0]     words_s;
  logic [15:0]     plen_s;
  logic [15:0]     exp_words_s;
  logic [1:0]      restart_inc_s;
  logic            frm_ready_s;
  logic            frm_bank_s;
  logic [15:0]     frm_len_s;

`ifdef UDP_RX_PORT_FILTER_EN
  // Only frames addressed to our port are buffered; others vanish silently.
  always_comb begin
    port_ok_s = (bus.rx_dst_port == RX_PORT);
  end
`else
  logic unused_port_s;
  // Port is not qualified in this build.
  always_comb begin
    port_ok_s     = 1'b1;
    unused_port_s = (bus.rx_dst_port == RX_PORT);
  end
`endif

  // Header evaluation, word accounting and commit decision.
  always_comb begin
    len_ok_s      = (bus.rx_len >= UDP_HDR_BYTES);
    hdr_ok_s      = port_ok_s && len_ok_s;
    plen_s        = bus.rx_len - UDP_HDR_BYTES;
    exp_words_s   = (plen_s + 16'd3) >> 2;
    words_s       = wcnt_r + {15'd0, bus.rx_word_valid};
    overflow_s    = bus.rx_word_valid && (wcnt_r == BANK_WORDS);
    restart_inc_s = (port_ok_s && !len_ok_s) ? 2'd2 : 2'd1;
    commit_s      = (state_r == W_FILL) && !bus.rx_start && bus.rx_end &&
                    !overflow_s && (words_s == exp_words_r);
  end

  // Writer FSM with registered RAM write port and drop counter.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_r     <= W_IDLE;
      wcnt_r      <= 16'd0;
      exp_words_r <= 16'd0;
      len_r       <= 16'd0;
      drop_cnt_r  <= 16'd0;
      ram_we_r    <= 1'b0;
      ram_waddr_r <= '0;
      ram_wdata_r <= 32'd0;
    end else begin
      ram_we_r <= 1'b0;
      case (state_r)
        W_IDLE, W_DROP: begin
          if (bus.rx_start) begin
            if (hdr_ok_s && !full_s) begin
              state_r     <= W_FILL;
              wcnt_r      <= 16'd0;
              exp_words_r <= exp_words_s;
              len_r       <= plen_s;
            end else begin
              state_r <= W_DROP;
              if (port_ok_s) begin
                drop_cnt_r <= sat_add(drop_cnt_r, 2'd1);
              end
            end
          end else if (bus.rx_end) begin
            state_r <= W_IDLE;
          end
        end
        W_FILL: begin
          if (bus.rx_start) begin
            // Receiver restarted: the bank being filled is still free, so reuse it.
            wcnt_r <= 16'd0;
            if (hdr_ok_s) begin
              exp_words_r <= exp_words_s;
              len_r       <= plen_s;
              drop_cnt_r  <= sat_add(drop_cnt_r, 2'd1);
            end else begin
              state_r    <= W_DROP;
              drop_cnt_r <= sat_add(drop_cnt_r, restart_inc_s);
            end
          end else if (overflow_s) begin
            drop_cnt_r <= sat_add(drop_cnt_r, 2'd1);
            state_r    <= bus.rx_end ? W_IDLE : W_DROP;
          end else begin
            if (bus.rx_word_valid) begin
              ram_we_r    <= 1'b1;
              ram_waddr_r <= {wr_bank_s, wcnt_r[ADDR_W-1:0]};
              ram_wdata_r <= bus.rx_word;
              wcnt_r      <= words_s;
            end
            if (bus.rx_end) begin
              state_r <= W_IDLE;
              if (!commit_s) begin
                drop_cnt_r <= sat_add(drop_cnt_r, 2'd1);
              end
            end
          end
        end
        default: begin
          state_r <= W_IDLE;
        end
      endcase
    end
  end

  udp_rx_desc_q u_desc_q (
    .clk       (clk),
    .clr       (clr),
    .push      (commit_s),
    .push_len  (len_r),
    .pop_req   (bus.frm_ack),
    .wr_bank   (wr_bank_s),
    .full      (full_s),
    .frm_ready (frm_ready_s),
    .frm_bank  (frm_bank_s),
    .frm_len   (frm_len_s)
  );

  assign bus.ram_we    = ram_we_r;
  assign bus.ram_waddr = ram_waddr_r;
  assign bus.ram_wdata = ram_wdata_r;
  assign bus.frm_ready = frm_ready_s;
  assign bus.frm_bank  = frm_bank_s;
  assign bus.frm_len   = frm_len_s;
  assign bus.drop_cnt  = drop_cnt_r;

endmodule

// File: doc/udp_rx_buf_ctrl.md
# udp_rx_buf_ctrl

Ping-pong receive-buffer controller between the GMII UDP receiver and the downstream command/parameter consumer. Sequences the receiver's 32-bit payload words into one of two RAM banks, validates each frame's word count against its UDP length, and hands completed frames to the consumer with a ready/ack handshake. Frames are dropped when no bank is free, on overflow or on a length mismatch.

## Interface
- ADDR_W, 9: word-address width per bank (512 words/bank).
- RX_PORT, 16'h1F90: accepted UDP destination port (used only with the filter macro).
- clk  in  1  receive clock (GMII RX domain)
- clr  in  1  synchronous active-low reset
- rx_start  in  1  one-cycle pulse: UDP header accepted, payload follows
- rx_len  in  16  UDP length field (includes 8 header bytes), valid with rx_start
- rx_dst_port  in  16  UDP destination port, valid with rx_start
- rx_word  in  32  payload word, first byte in [31:24], zero-padded tail
- rx_word_valid  in  1  rx_word strobe
- rx_end  in  1  one-cycle pulse: frame complete; may coincide with the final rx_word_valid
- ram_we  out  1  bank RAM write enable
- ram_waddr  out  ADDR_W+1  {bank, word address}
- ram_wdata  out  32  write data
- frm_ready  out  1  a committed frame is available
- frm_bank  out  1  bank that holds the presented frame
- frm_len  out  16  payload bytes of the presented frame (rx_len-8)
- frm_ack  in  1  one-cycle pulse: consumer done, release bank
- drop_cnt  out  16  saturating count of dropped frames

## Operation
- Writer FSM: W_IDLE, W_FILL, W_DROP. Bank bookkeeping: wr_bank, rd_bank (1 bit each), count (0..2), one frm_len register per bank.
- W_IDLE + rx_start: if count==2 → W_DROP, drop_cnt+1. Otherwise → W_FILL, waddr=0, latch exp_words=ceil((rx_len-8)/4) and len.
- rx_len<8 at rx_start → W_DROP, drop_cnt+1.
- W_FILL: each rx_word_valid writes rx_word to {wr_bank, waddr} and increments waddr. A word that would go beyond 2^ADDR_W → W_DROP, drop_cnt+1, nothing further written.
- W_FILL + rx_end: if words written (including a coincident final word) == exp_words, commit: store len, toggle wr_bank, count+1 → W_IDLE. Otherwise discard, drop_cnt+1 → W_IDLE.
- W_FILL + rx_start (previous frame truncated, receiver restarted): discard the partial frame, drop_cnt+1, re-enter W_FILL in the same bank with the new header.
- W_DROP: ignore words. rx_end → W_IDLE. rx_start → re-evaluate as in W_IDLE.
- Reader: frm_ready = (count!=0). frm_bank = rd_bank. frm_len = len[rd_bank]. frm_ack with frm_ready=1 toggles rd_bank and decrements count. frm_ack with frm_ready=0 is ignored.
- Commit and ack in the same cycle: count unchanged, both pointers advance.
- drop_cnt saturates at 16'hFFFF.

## Timing
- Reset (clr=0 at a clk edge): state W_IDLE, wr_bank=rd_bank=0, count=0. All outputs 0: ram_we, ram_waddr, ram_wdata, frm_ready, frm_bank, frm_len, drop_cnt. A reset mid-frame discards everything.
- Write path is registered: ram_we/ram_waddr/ram_wdata are valid 1 cycle after rx_word_valid.
- frm_ready rises 1 cycle after the rx_end commit edge (i.e. with the final RAM write, which is therefore complete).
- frm_ready/frm_bank/frm_len update 1 cycle after frm_ack.
- Back-to-back frames: rx_start is accepted on the cycle after rx_end.

## Configuration
- UDP_RX_PORT_FILTER_EN defined: at rx_start, rx_dst_port!=RX_PORT → W_DROP without incrementing drop_cnt.
- Undefined: rx_dst_port is ignored and all frames are buffered.

## Structure
- Package udp_rx_pkg: writer-state enum (W_IDLE/W_FILL/W_DROP), UDP_HDR_BYTES=8, DROP_CNT_MAX.
- One natural sub-module: udp_rx_desc_q, the 2-entry bank/length descriptor queue (pointers, count, simultaneous push/pop).

## Test plan
- rx_len=20 (12 payload bytes), 3 words → 3 writes at addr 0..2 of bank 0. Then frm_ready=1, frm_bank=0, frm_len=12.
- Two frames with no ack, then a third → third frame dropped, drop_cnt=1, no ram_we. After frm_ack, frm_bank=1.
- rx_len=17 (9 bytes → 3 words) but only 2 words before rx_end → discarded, drop_cnt=1, frm_ready stays 0.
- rx_start mid-fill, then a valid 1-word frame → bank 0 holds only the new frame, frm_len matches the new rx_len, drop_cnt=1.
- Commit and frm_ack in the same cycle with count=1 → count stays 1, wr_bank and rd_bank both toggle.
- With UDP_RX_PORT_FILTER_EN: rx_dst_port=16'h0050 → no writes, drop_cnt=0. rx_dst_port=16'h1F90 → frame is buffered.
